// File: rtl/framebuffer_pkg.sv
// Shared framebuffer definitions: writer FSM states, command opcodes, default
// geometry and the {row, pixel, hi_lo} byte-address packing used by writer and reader.
package framebuffer_pkg;

  localparam int         ROW_BITS   = 5;
  localparam int         PIXEL_BITS = 6;
  localparam logic [7:0] CMD_LOAD   = 8'h4C;
  localparam logic [7:0] CMD_CLEAR  = 8'h43;

  typedef enum logic [1:0] {
    IDLE,
    GET_ROW,
    DATA,
    CLEAR
  } fb_state_t;

  // Byte address of one half of a pixel; hi_lo=1 selects the high byte.
  function automatic logic [31:0] pack_addr(input logic [31:0] row,
                                            input logic [31:0] pixel,
                                            input logic        hi_lo,
                                            input int          pixel_bits);
    return (row << (pixel_bits + 1)) | (pixel << 1) | {31'd0, hi_lo};
  endfunction

endpackage

// File: rtl/framebuffer_row_writer.sv
// Turns the 'L'/'C' command byte stream into framebuffer port-A byte writes; writes are
// registered one cycle after acceptance, and data_ready drops only while a clear sweeps the RAM.
module framebuffer_row_writer
  import framebuffer_pkg::*;
#(
  parameter int         ROW_BITS   = framebuffer_pkg::ROW_BITS,
  parameter int         PIXEL_BITS = framebuffer_pkg::PIXEL_BITS,
  parameter int         ADDR_WIDTH = 12,
  parameter logic [7:0] CMD_LOAD   = framebuffer_pkg::CMD_LOAD,
  parameter logic [7:0] CMD_CLEAR  = framebuffer_pkg::CMD_CLEAR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]            ram_data_out,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable,
  output logic                  row_done,
  output logic                  clear_done,
  output logic                  cmd_error
);

  if (ADDR_WIDTH != ROW_BITS + PIXEL_BITS + 1) begin : g_bad_geometry
    $error("ADDR_WIDTH must equal ROW_BITS + PIXEL_BITS + 1");
  end

  fb_state_t               state, state_n;
  logic [ROW_BITS-1:0]     row_q, row_n;
  logic [PIXEL_BITS-1:0]   pixel_q, pixel_n;
  logic                    hi_lo_q, hi_lo_n;
  logic [ADDR_WIDTH-1:0]   clr_q, clr_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [7:0]              wdata_n;
  logic                    we_n, ready_n, row_done_n, clear_done_n, cmd_error_n;
  logic                    accept, row_ok;

  assign accept         = data_valid && data_ready;
  assign row_ok         = int'(data_in) < (1 << ROW_BITS);
  assign ram_clk_enable = ram_write_enable;

  always_comb begin
    state_n      = state;
    row_n        = row_q;
    pixel_n      = pixel_q;
    hi_lo_n      = hi_lo_q;
    clr_n        = clr_q;
    addr_n       = ram_address;
    wdata_n      = ram_data_out;
    we_n         = 1'b0;
    row_done_n   = 1'b0;
    clear_done_n = 1'b0;
    cmd_error_n  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (data_in == CMD_LOAD) begin
            state_n = GET_ROW;
          end else if (data_in == CMD_CLEAR) begin
            state_n = CLEAR;
            clr_n   = '0;
          end else begin
            cmd_error_n = 1'b1;
          end
        end
      end
      GET_ROW: begin
        if (accept) begin
          if (row_ok) begin
            row_n   = data_in[ROW_BITS-1:0];
            pixel_n = '0;
            hi_lo_n = 1'b1;
            state_n = DATA;
          end else begin
            cmd_error_n = 1'b1;
            state_n     = IDLE;
          end
        end
      end
      DATA: begin
        if (accept) begin
          we_n    = 1'b1;
          addr_n  = ADDR_WIDTH'(pack_addr(32'(row_q), 32'(pixel_q), hi_lo_q, PIXEL_BITS));
          wdata_n = data_in;
          if (hi_lo_q) begin
            hi_lo_n = 1'b0;
          end else begin
            hi_lo_n = 1'b1;
            // The low byte of the last pixel closes the row.
            if (pixel_q == {PIXEL_BITS{1'b1}}) begin
              pixel_n    = '0;
              row_done_n = 1'b1;
              state_n    = IDLE;
            end else begin
              pixel_n = pixel_q + 1'b1;
            end
          end
        end
      end
      CLEAR: begin
        we_n    = 1'b1;
        addr_n  = clr_q;
        wdata_n = 8'h00;
        if (clr_q == {ADDR_WIDTH{1'b1}}) begin
          clr_n        = '0;
          clear_done_n = 1'b1;
          state_n      = IDLE;
        end else begin
          clr_n = clr_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    ready_n = (state_n != CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      row_q            <= '0;
      pixel_q          <= '0;
      hi_lo_q          <= 1'b0;
      clr_q            <= '0;
      data_ready       <= 1'b0;
      ram_address      <= '0;
      ram_data_out     <= '0;
      ram_write_enable <= 1'b0;
      row_done         <= 1'b0;
      clear_done       <= 1'b0;
      cmd_error        <= 1'b0;
    end else begin
      state            <= state_n;
      row_q            <= row_n;
      pixel_q          <= pixel_n;
      hi_lo_q          <= hi_lo_n;
      clr_q            <= clr_n;
      data_ready       <= ready_n;
      ram_address      <= addr_n;
      ram_data_out     <= wdata_n;
      ram_write_enable <= we_n;
      row_done         <= row_done_n;
      clear_done       <= clear_done_n;
      cmd_error        <= cmd_error_n;
    end
  end

endmodule

// File: tb/tb_framebuffer_row_writer.sv
// Bench for framebuffer_row_writer: scoreboard of expected RAM writes plus a byte-wide RAM model.
module tb_framebuffer_row_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_out;
  logic        ram_write_enable, ram_clk_enable;
  logic        row_done, clear_done, cmd_error;

  framebuffer_row_writer dut (
    .clk              (clk),
    .reset            (reset),
    .data_in          (data_in),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .ram_address      (ram_address),
    .ram_data_out     (ram_data_out),
    .ram_write_enable (ram_write_enable),
    .ram_clk_enable   (ram_clk_enable),
    .row_done         (row_done),
    .clear_done       (clear_done),
    .cmd_error        (cmd_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        last_row;
    logic        last_clr;
  } wr_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    bit         has_b1;
    bit         exp_err;
  } vec_t;

  wr_t        exp_q[$];
  wr_t        e;
  logic [7:0] mem [0:4095];
  int checks = 0, errors = 0, cycle = 0, writes = 0;
  int row_done_cnt = 0, clear_done_cnt = 0, err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cycle++;

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_error)  err_cnt++;
      if (row_done)   row_done_cnt++;
      if (clear_done) clear_done_cnt++;
      if (ram_write_enable) begin
        writes++;
        mem[ram_address] = ram_data_out;
        check("clk_en_with_we", ram_clk_enable, 1);
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", ram_address, e.addr);
          check("wr_data", ram_data_out, e.data);
          check("row_done_align", row_done, e.last_row);
          check("clear_done_align", clear_done, e.last_clr);
        end
      end else if (ram_clk_enable || row_done || clear_done) begin
        check("strobe_without_write", {ram_clk_enable, row_done, clear_done}, 0);
      end
    end
  end

  // Called at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    data_in    = b;
    data_valid = 1'b1;
    while (!data_ready && guard < 10000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!data_ready) check("ready_timeout", data_ready, 1);
    else begin
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
  endtask

  task automatic push_row(input logic [4:0] row, input logic [7:0] base, input int nbytes);
    wr_t w;
    for (int i = 0; i < nbytes; i++) begin
      w.addr     = {row, 6'(i / 2), ~i[0]};
      w.data     = base + 8'(i);
      w.last_row = (i == 127);
      w.last_clr = 1'b0;
      exp_q.push_back(w);
    end
  endtask

  task automatic load_row(input logic [4:0] row, input logic [7:0] base, input bit gaps,
                          output int elapsed);
    int t0;
    push_row(row, base, 128);
    send_byte(8'h4C);
    send_byte({3'b000, row});
    t0 = cycle;
    for (int i = 0; i < 128; i++) begin
      send_byte(base + 8'(i));
      if (gaps) begin
        @(posedge clk); #1;
      end
    end
    elapsed = cycle - t0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_ready"}, data_ready, 0);
    check({tag, "_ram_address"}, ram_address, 0);
    check({tag, "_ram_data_out"}, ram_data_out, 0);
    check({tag, "_ram_we"}, ram_write_enable, 0);
    check({tag, "_ram_ce"}, ram_clk_enable, 0);
    check({tag, "_row_done"}, row_done, 0);
    check({tag, "_clear_done"}, clear_done, 0);
    check({tag, "_cmd_error"}, cmd_error, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int elapsed, w0, low;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{8'h6C, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h4C, 8'h20, 1'b1, 1'b1};
    vecs[4] = '{8'h4C, 8'hFF, 1'b1, 1'b1};
    vecs[5] = '{8'h4C, 8'h40, 1'b1, 1'b1};

    #1 reset = 1'b1;
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", data_ready, 1);

    // Row 31, back-to-back bytes.
    load_row(5'h1F, 8'h41, 1'b0, elapsed);
    check("row31_no_bubbles", elapsed, 128);
    check("row31_row_done_cnt", row_done_cnt, 1);
    check("row31_first_word", {mem[12'hF81], mem[12'hF80]}, 16'h4142);
    check("row31_last_word", {mem[12'hFFF], mem[12'hFFE]}, {8'h41 + 8'd126, 8'h41 + 8'd127});

    // Bad opcodes and bad row indices.
    for (int v = 0; v < 6; v++) begin
      w0 = writes;
      send_byte(vecs[v].b0);
      if (vecs[v].has_b1) begin
        check($sformatf("vec%0d_no_early_err", v), cmd_error, 0);
        send_byte(vecs[v].b1);
      end
      check($sformatf("vec%0d_cmd_error", v), cmd_error, vecs[v].exp_err);
      @(posedge clk); #1;
      check($sformatf("vec%0d_err_one_cycle", v), cmd_error, 0);
      check($sformatf("vec%0d_no_write", v), writes - w0, 0);
    end
    check("err_pulse_count", err_cnt, 6);

    // Row 0 after the errors, with valid toggling.
    load_row(5'h00, 8'h10, 1'b1, elapsed);
    check("row0_row_done_cnt", row_done_cnt, 2);
    check("row0_first_word", {mem[12'h001], mem[12'h000]}, 16'h1011);
    check("row0_last_word", {mem[12'h07F], mem[12'h07E]}, {8'h10 + 8'd126, 8'h10 + 8'd127});

    // Full clear.
    for (int a = 0; a < 4096; a++) exp_q.push_back('{addr: 12'(a), data: 8'h00, last_row: 1'b0, last_clr: (a == 4095)});
    w0 = writes;
    send_byte(8'h43);
    low = 0;
    while (!data_ready && low < 5000) begin
      @(posedge clk); #1;
      low++;
    end
    check("clear_ready_low_cycles", low, 4096);
    check("clear_done_at_ready", clear_done, 1);
    check("clear_last_addr", ram_address, 12'hFFF);
    repeat (2) @(posedge clk);
    #1;
    check("clear_write_count", writes - w0, 4096);
    check("clear_done_cnt", clear_done_cnt, 1);
    check("clear_zeroed_row31", {mem[12'hF81], mem[12'hF80]}, 0);

    // Reset in the middle of a row.
    push_row(5'h05, 8'h80, 10);
    send_byte(8'h4C);
    send_byte(8'h05);
    for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i));
    #6 reset = 1'b1;
    #1 check_all_zero("midrow_reset");
    check("midrow_queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_midrow_reset", data_ready, 1);
    load_row(5'h03, 8'hC0, 1'b0, elapsed);
    check("fresh_row_done_cnt", row_done_cnt, 3);
    check("fresh_row_first_word", {mem[12'h181], mem[12'h180]}, 16'hC0C1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
